// File: rtl/commit_ctrl_pkg.sv
// Shared definitions for the commit controller: ROB index width,
// commit type codes carried with each ROB head entry, and the
// controller FSM state encoding.
package commit_ctrl_pkg;

  localparam int ROB_WIDTH_BIT = 4;

  typedef enum logic [1:0] {
    CM_REG  = 2'd0,
    CM_BR   = 2'd1,
    CM_ST   = 2'd2,
    CM_HALT = 2'd3
  } cm_type_e;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_ST   = 3'd1,
    ST_PRE_FLUSH = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_HALTED    = 3'd4
  } state_e;

  // A head entry can retire this cycle only when the pipeline is not
  // paused and the ROB reports a completed result at its head.
  function automatic logic headGo(input logic rdy, input logic valid, input logic ready);
    return rdy & valid & ready;
  endfunction

endpackage

// File: rtl/commit_ctrl_if.sv
// Commit bus bundle between the ROB/LSB/RegFile/fetch side and the
// commit controller.
//   head_*        : ROB head entry presented for retirement
//   commit_pop    : ROB dequeues the head at this edge
//   write_*       : RegFile write port (write_reg_id 0 = no write)
//   store_commit  : LSB may perform the head store; store_done ends it
//   clear_flag    : global flush
//   redirect_*    : fetch restart after a mispredicted branch
//   halt          : sticky after a HALT retires
//   commit_count  : retired-instruction counter
// master = the commit controller, slave = the surrounding pipeline.
interface commit_ctrl_if;
  import commit_ctrl_pkg::*;

  logic                     head_valid;
  logic                     head_ready;
  logic [ROB_WIDTH_BIT-1:0] head_rob_id;
  cm_type_e                 head_type;
  logic [4:0]               head_rd;
  logic [31:0]              head_val;
  logic                     head_mispred;
  logic [31:0]              head_target;
  logic                     commit_pop;
  logic [4:0]               write_reg_id;
  logic [ROB_WIDTH_BIT-1:0] write_ROB_id;
  logic [31:0]              write_val;
  logic                     store_commit;
  logic                     store_done;
  logic                     clear_flag;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     halt;
  logic [31:0]              commit_count;

  modport master (
    input  head_valid, head_ready, head_rob_id, head_type, head_rd,
           head_val, head_mispred, head_target, store_done,
    output commit_pop, write_reg_id, write_ROB_id, write_val,
           store_commit, clear_flag, redirect_valid, redirect_pc,
           halt, commit_count
  );

  modport slave (
    output head_valid, head_ready, head_rob_id, head_type, head_rd,
           head_val, head_mispred, head_target, store_done,
    input  commit_pop, write_reg_id, write_ROB_id, write_val,
           store_commit, clear_flag, redirect_valid, redirect_pc,
           halt, commit_count
  );

endinterface

// File: rtl/commit_ctrl.sv
// In-order commit controller. Retires at most one ROB head per cycle
// into the RegFile write port, handshakes stores with the LSB, and on a
// mispredicted branch issues a redirect plus a FLUSH_CYCLES-long
// clear_flag. A retired HALT stops all further commits until reset.
// Ports:
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   rdy_in  : pause when low, all state frozen
//   bus     : commit_ctrl_if master modport (ROB head, RegFile write,
//             LSB store handshake, flush/redirect, halt, counter)
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  commit_ctrl_if.master bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e                   state_q;
  logic [CNT_W-1:0]         flushCnt_q;
  logic [4:0]               writeRegId_q;
  logic [ROB_WIDTH_BIT-1:0] writeRobId_q;
  logic [31:0]              writeVal_q;
  logic                     clearFlag_q;
  logic                     redirectValid_q;
  logic [31:0]              redirectPc_q;
  logic                     halt_q;
  logic [31:0]              commitCount_q;
  logic [31:0]              commitCount_d;
  logic                     go;

  assign go            = headGo(rdy_in, bus.head_valid, bus.head_ready);
  assign commitCount_d = commitCount_q + 32'd1;

  // Pop is combinational so the ROB dequeues on the same edge the
  // controller latches the head. Stores only pop once the LSB reports
  // completion; nothing pops while flushing or halted.
  always_comb begin
    bus.commit_pop = 1'b0;
    case (state_q)
      ST_RUN:     bus.commit_pop = go && (bus.head_type != CM_ST);
      ST_WAIT_ST: bus.commit_pop = rdy_in && bus.store_done;
      default:    bus.commit_pop = 1'b0;
    endcase
  end

  assign bus.store_commit   = (state_q == ST_WAIT_ST);
  assign bus.write_reg_id   = writeRegId_q;
  assign bus.write_ROB_id   = writeRobId_q;
  assign bus.write_val      = writeVal_q;
  assign bus.clear_flag     = clearFlag_q;
  assign bus.redirect_valid = redirectValid_q;
  assign bus.redirect_pc    = redirectPc_q;
  assign bus.halt           = halt_q;
  assign bus.commit_count   = commitCount_q;

  // Commit FSM. write_* and redirect_valid are one-cycle pulses that are
  // cleared on every active edge unless refreshed by a new commit. The
  // PRE_FLUSH cycle exists so the branch link write reaches the RegFile
  // before clear_flag rises, since the RegFile drops writes during a flush.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= ST_RUN;
      flushCnt_q      <= '0;
      writeRegId_q    <= '0;
      writeRobId_q    <= '0;
      writeVal_q      <= '0;
      clearFlag_q     <= 1'b0;
      redirectValid_q <= 1'b0;
      redirectPc_q    <= '0;
      halt_q          <= 1'b0;
      commitCount_q   <= '0;
    end else if (rdy_in) begin
      writeRegId_q    <= '0;
      writeRobId_q    <= '0;
      writeVal_q      <= '0;
      redirectValid_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (go) begin
            case (bus.head_type)
              CM_REG, CM_BR: begin
                writeRegId_q  <= bus.head_rd;
                writeRobId_q  <= bus.head_rob_id;
                writeVal_q    <= bus.head_val;
                commitCount_q <= commitCount_d;
                if (bus.head_type == CM_BR && bus.head_mispred) begin
                  redirectPc_q    <= bus.head_target;
                  redirectValid_q <= 1'b1;
                  state_q         <= ST_PRE_FLUSH;
                end
              end
              CM_ST: state_q <= ST_WAIT_ST;
              default: begin
                commitCount_q <= commitCount_d;
                halt_q        <= 1'b1;
                state_q       <= ST_HALTED;
              end
            endcase
          end
        end
        ST_WAIT_ST: begin
          if (bus.store_done) begin
            commitCount_q <= commitCount_d;
            state_q       <= ST_RUN;
          end
        end
        ST_PRE_FLUSH: begin
          clearFlag_q <= 1'b1;
          flushCnt_q  <= CNT_W'(FLUSH_CYCLES - 1);
          state_q     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flushCnt_q == '0) begin
            clearFlag_q <= 1'b0;
            state_q     <= ST_RUN;
          end else begin
            flushCnt_q <= flushCnt_q - 1'b1;
          end
        end
        default: halt_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl. Expected RegFile writes are queued
// when a head is presented and compared by a monitor when the controller
// presents them on an rdy-high cycle; scenario tasks check pop, flush,
// store, pause, stall and halt behaviour inline.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  typedef struct {
    logic [4:0]               rd;
    logic [ROB_WIDTH_BIT-1:0] rob;
    logic [31:0]              val;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  int          checks = 0;
  int          errors = 0;
  int          expCount = 0;
  exp_t        expQ[$];
  exp_t        monExp;

  commit_ctrl_if bus ();

  commit_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  // 10-unit clock; inputs change 1 unit after the rising edge and
  // outputs are sampled on the falling edge.
  always #5 clk_in = ~clk_in;

  // Scoreboard monitor: a write counts as consumed on an rdy-high cycle.
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && bus.write_reg_id != 5'd0) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL write_unexpected got rd=%0d rob=%0d val=%h required none",
                 bus.write_reg_id, bus.write_ROB_id, bus.write_val);
      end else begin
        monExp = expQ.pop_front();
        if (bus.write_reg_id !== monExp.rd || bus.write_ROB_id !== monExp.rob ||
            bus.write_val !== monExp.val) begin
          errors++;
          $display("[TB] FAIL write_fields got rd=%0d rob=%0d val=%h required rd=%0d rob=%0d val=%h",
                   bus.write_reg_id, bus.write_ROB_id, bus.write_val,
                   monExp.rd, monExp.rob, monExp.val);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout got running required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic ready,
                               input logic [ROB_WIDTH_BIT-1:0] id, input cm_type_e t,
                               input logic [4:0] rd, input logic [31:0] val,
                               input logic mispred, input logic [31:0] target);
    bus.head_valid   = valid;
    bus.head_ready   = ready;
    bus.head_rob_id  = id;
    bus.head_type    = t;
    bus.head_rd      = rd;
    bus.head_val     = val;
    bus.head_mispred = mispred;
    bus.head_target  = target;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, '0, CM_REG, 5'd0, 32'd0, 1'b0, 32'd0);
    bus.store_done = 1'b0;
    rdy_in = 1'b1;
    #2 rst_in = 1'b0;
    cyc();
    cyc();
    @(negedge clk_in);
    checks++;
    if ({bus.commit_pop, bus.store_commit, bus.clear_flag, bus.redirect_valid, bus.halt} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b required 00000",
               {bus.commit_pop, bus.store_commit, bus.clear_flag, bus.redirect_valid, bus.halt});
    end
    checks++;
    if (bus.write_reg_id !== 5'd0 || bus.commit_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs got rd=%0d count=%0d required 0 0",
               bus.write_reg_id, bus.commit_count);
    end
    cyc();
    rst_in = 1'b1;
    expCount = 0;
  endtask

  task automatic test_reg_burst();
    for (int i = 0; i < 3; i++) begin
      cyc();
      applyStimulus(1'b1, 1'b1, 4'(i + 1), CM_REG, 5'(5 + i), 32'h1000_0000 + 32'(i), 1'b0, 32'd0);
      expQ.push_back('{rd: 5'(5 + i), rob: 4'(i + 1), val: 32'h1000_0000 + 32'(i)});
      expCount++;
      @(negedge clk_in);
      checks++;
      if (bus.commit_pop !== 1'b1) begin
        errors++;
        $display("[TB] FAIL burst_pop%0d got %b required 1", i, bus.commit_pop);
      end
    end
    cyc();
    bus.head_valid = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.commit_pop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_nopop got %b required 0", bus.commit_pop);
    end
    cyc();
    @(negedge clk_in);
    checks++;
    if (bus.write_reg_id !== 5'd0 || bus.commit_count !== 32'(expCount)) begin
      errors++;
      $display("[TB] FAIL burst_end got rd=%0d count=%0d required 0 %0d",
               bus.write_reg_id, bus.commit_count, expCount);
    end
  endtask

  task automatic test_branch_mispred();
    cyc();
    applyStimulus(1'b1, 1'b1, 4'd9, CM_BR, 5'd1, 32'hAAAA_0004, 1'b1, 32'h0000_0100);
    expQ.push_back('{rd: 5'd1, rob: 4'd9, val: 32'hAAAA_0004});
    expCount++;
    @(negedge clk_in);
    checks++;
    if (bus.commit_pop !== 1'b1 || bus.clear_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL br_pop got pop=%b clr=%b required 1 0", bus.commit_pop, bus.clear_flag);
    end
    cyc();
    applyStimulus(1'b1, 1'b1, 4'd10, CM_REG, 5'd20, 32'hDEAD_BEEF, 1'b0, 32'd0);
    @(negedge clk_in);
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h100 ||
        bus.clear_flag !== 1'b0 || bus.commit_pop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL br_n1 got rv=%b pc=%h clr=%b pop=%b required 1 00000100 0 0",
               bus.redirect_valid, bus.redirect_pc, bus.clear_flag, bus.commit_pop);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk_in);
      checks++;
      if (bus.clear_flag !== 1'b1 || bus.redirect_valid !== 1'b0 ||
          bus.commit_pop !== 1'b0 || bus.write_reg_id !== 5'd0) begin
        errors++;
        $display("[TB] FAIL br_flush%0d got clr=%b rv=%b pop=%b rd=%0d required 1 0 0 0",
                 k, bus.clear_flag, bus.redirect_valid, bus.commit_pop, bus.write_reg_id);
      end
    end
    cyc();
    bus.head_valid = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.clear_flag !== 1'b0 || bus.commit_count !== 32'(expCount)) begin
      errors++;
      $display("[TB] FAIL br_end got clr=%b count=%0d required 0 %0d",
               bus.clear_flag, bus.commit_count, expCount);
    end
  endtask

  task automatic test_store();
    cyc();
    applyStimulus(1'b1, 1'b1, 4'd3, CM_ST, 5'd0, 32'h0, 1'b0, 32'd0);
    @(negedge clk_in);
    checks++;
    if (bus.commit_pop !== 1'b0 || bus.store_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL st_start got pop=%b sc=%b required 0 0", bus.commit_pop, bus.store_commit);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      bus.store_done = (k == 4);
      @(negedge clk_in);
      checks++;
      if (bus.store_commit !== 1'b1 || bus.commit_pop !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL st_wait%0d got sc=%b pop=%b required 1 %b",
                 k, bus.store_commit, bus.commit_pop, (k == 4));
      end
    end
    expCount++;
    cyc();
    bus.store_done = 1'b0;
    bus.head_valid = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.store_commit !== 1'b0 || bus.write_reg_id !== 5'd0 ||
        bus.commit_count !== 32'(expCount)) begin
      errors++;
      $display("[TB] FAIL st_end got sc=%b rd=%0d count=%0d required 0 0 %0d",
               bus.store_commit, bus.write_reg_id, bus.commit_count, expCount);
    end
  endtask

  task automatic test_rdy_pause();
    cyc();
    applyStimulus(1'b1, 1'b1, 4'd4, CM_REG, 5'd9, 32'h0000_0099, 1'b0, 32'd0);
    expQ.push_back('{rd: 5'd9, rob: 4'd4, val: 32'h0000_0099});
    expCount++;
    @(negedge clk_in);
    checks++;
    if (bus.commit_pop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_pop got %b required 1", bus.commit_pop);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      rdy_in = 1'b0;
      applyStimulus(1'b1, 1'b1, 4'd5, CM_REG, 5'd10, 32'h0000_00AA, 1'b0, 32'd0);
      @(negedge clk_in);
      checks++;
      if (bus.write_reg_id !== 5'd9 || bus.commit_pop !== 1'b0 ||
          bus.commit_count !== 32'(expCount)) begin
        errors++;
        $display("[TB] FAIL pause_hold%0d got rd=%0d pop=%b count=%0d required 9 0 %0d",
                 k, bus.write_reg_id, bus.commit_pop, bus.commit_count, expCount);
      end
    end
    cyc();
    rdy_in = 1'b1;
    bus.head_valid = 1'b0;
    cyc();
    @(negedge clk_in);
    checks++;
    if (bus.write_reg_id !== 5'd0) begin
      errors++;
      $display("[TB] FAIL pause_consumed got rd=%0d required 0", bus.write_reg_id);
    end
  endtask

  task automatic test_stall();
    cyc();
    applyStimulus(1'b1, 1'b0, 4'd6, CM_REG, 5'd12, 32'h0000_0C0C, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      checks++;
      if (bus.commit_pop !== 1'b0 || bus.write_reg_id !== 5'd0 ||
          bus.commit_count !== 32'(expCount)) begin
        errors++;
        $display("[TB] FAIL stall%0d got pop=%b rd=%0d count=%0d required 0 0 %0d",
                 k, bus.commit_pop, bus.write_reg_id, bus.commit_count, expCount);
      end
      cyc();
    end
    bus.head_valid = 1'b0;
  endtask

  task automatic test_halt();
    cyc();
    applyStimulus(1'b1, 1'b1, 4'd7, CM_HALT, 5'd0, 32'h0, 1'b0, 32'd0);
    expCount++;
    @(negedge clk_in);
    checks++;
    if (bus.commit_pop !== 1'b1 || bus.halt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_pop got pop=%b halt=%b required 1 0", bus.commit_pop, bus.halt);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      applyStimulus(1'b1, 1'b1, 4'(8 + k), CM_REG, 5'd3, 32'h0000_0333, 1'b0, 32'd0);
      @(negedge clk_in);
      checks++;
      if (bus.halt !== 1'b1 || bus.commit_pop !== 1'b0 ||
          bus.commit_count !== 32'(expCount)) begin
        errors++;
        $display("[TB] FAIL halt_sticky%0d got halt=%b pop=%b count=%0d required 1 0 %0d",
                 k, bus.halt, bus.commit_pop, bus.commit_count, expCount);
      end
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (bus.halt !== 1'b0 || bus.commit_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL halt_async_reset got halt=%b count=%0d required 0 0",
               bus.halt, bus.commit_count);
    end
    bus.head_valid = 1'b0;
    cyc();
    rst_in = 1'b1;
    expCount = 0;
  endtask

  initial begin
    test_reset();
    test_reg_burst();
    test_branch_mispred();
    test_store();
    test_rdy_pause();
    test_stall();
    test_halt();
    cyc();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
